controlador_lectura_pixeles: RTL

Sequencer between word-aligned image memory and the pixel buffer. Given a base word address and a pixel count, it issues 32-bit word reads and pushes each returned word into the buffer with `save_mem_data`. It throttles on `buffer_full` and counts pixels consumed downstream via `read_pixel`. It signals completion once every requested pixel has been both fetched and consumed. It sits between the memory port and the pixel buffer, driven by the filter top-level control.

---
 rtl/controlador_lectura_pixeles.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/controlador_lectura_pixeles.sv
// controlador_lectura_pixeles
// Fetches ceil(num_pixels/4) words from word-aligned image memory, starting at
// base_addr. Each returned word is pushed into the pixel buffer. The block then
// waits until downstream has consumed every requested pixel before it pulses done.
//
// Ports
//   clk, reset          : rising-edge clock, synchronous active-low reset
//   start               : request, accepted only while idle
//   base_addr           : first word address, latched on an accepted start
//   num_pixels          : pixel count, latched on an accepted start
//   mem_addr, mem_read  : read request; mem_read is a Mealy strobe, issued in REQ when the buffer has room
//   mem_data_valid      : memory response strobe
//   mem_data_in         : memory response data
//   memory_data         : registered word to the buffer
//   save_mem_data       : one-cycle buffer write strobe
//   buffer_full         : back-pressure from the buffer, sampled only in REQ
//   read_pixel          : one pixel consumed downstream this cycle
//   busy                : high outside IDLE
//   done                : one-cycle completion pulse
//   error (option)      : sticky memory timeout flag
//
// Build option
//   LECTOR_TIMEOUT_EN   : adds a 255-cycle WAIT watchdog and the error output
module controlador_lectura_pixeles #(
    parameter int unsigned ADDR_BITS     = 16,
    parameter int unsigned MEM_WORD_BITS = 32,
    parameter int unsigned PIXEL_BITS    = 8,
    parameter int unsigned COUNT_BITS    = 20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_BITS-1:0]     base_addr,
    input  logic [COUNT_BITS-1:0]    num_pixels,
    output logic [ADDR_BITS-1:0]     mem_addr,
    output logic                     mem_read,
    input  logic                     mem_data_valid,
    input  logic [MEM_WORD_BITS-1:0] mem_data_in,
    output logic [MEM_WORD_BITS-1:0] memory_data,
    output logic                     save_mem_data,
    input  logic                     buffer_full,
    input  logic                     read_pixel,
    output logic                     busy,
    output logic                     done
`ifdef LECTOR_TIMEOUT_EN
    ,
    output logic                     error
`endif
);

    localparam int unsigned PIX_PER_WORD = MEM_WORD_BITS / PIXEL_BITS;
    localparam int unsigned WORD_SHIFT   = $clog2(PIX_PER_WORD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WRITE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDR_BITS-1:0]     addr_q, addr_d;
    logic [COUNT_BITS-1:0]    words_left_q, words_left_d;
    logic [COUNT_BITS-1:0]    pix_leidos_q, pix_leidos_d;
    logic [COUNT_BITS-1:0]    n_pix_q, n_pix_d;
    logic [MEM_WORD_BITS-1:0] mem_data_q, mem_data_d;
    logic                     save_q, save_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     mem_read_c;
    logic [COUNT_BITS-1:0]    words_c;
`ifdef LECTOR_TIMEOUT_EN
    logic [7:0]               wd_q, wd_d;
    logic                     error_q, error_d;
`endif

    // Words to fetch, rounded up; one extra bit keeps the +3 from overflowing
    assign words_c = COUNT_BITS'(({1'b0, num_pixels} + (COUNT_BITS+1)'(PIX_PER_WORD - 1)) >> WORD_SHIFT);

    // Next-state and datapath
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        words_left_d = words_left_q;
        pix_leidos_d = pix_leidos_q;
        n_pix_d      = n_pix_q;
        mem_data_d   = mem_data_q;
        save_d       = 1'b0;
        mem_read_c   = 1'b0;
`ifdef LECTOR_TIMEOUT_EN
        wd_d         = wd_q;
        error_d      = error_q;
`endif

        // Consumed-pixel counter saturates at the requested count
        if (busy_q && read_pixel && (pix_leidos_q != n_pix_q)) begin
            pix_leidos_d = pix_leidos_q + COUNT_BITS'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef LECTOR_TIMEOUT_EN
                    error_d = 1'b0;
`endif
                    if (num_pixels != '0) begin
                        addr_d       = base_addr;
                        words_left_d = words_c;
                        n_pix_d      = num_pixels;
                        pix_leidos_d = '0;
                        state_d      = S_REQ;
                    end else begin
                        state_d      = S_DONE;
                    end
                end
            end
            S_REQ: begin
                if (!buffer_full) begin
                    mem_read_c = 1'b1;
                    state_d    = S_WAIT;
`ifdef LECTOR_TIMEOUT_EN
                    wd_d       = '0;
`endif
                end
            end
            S_WAIT: begin
                if (mem_data_valid) begin
                    mem_data_d = mem_data_in;
                    save_d     = 1'b1;
                    state_d    = S_WRITE;
                end
`ifdef LECTOR_TIMEOUT_EN
                // 255th silent WAIT cycle: abandon the transfer
                else if (wd_q == 8'd254) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
`endif
            end
            S_WRITE: begin
                addr_d       = addr_q + ADDR_BITS'(1);
                words_left_d = words_left_q - COUNT_BITS'(1);
                state_d      = (words_left_q == COUNT_BITS'(1)) ? S_DRAIN : S_REQ;
            end
            S_DRAIN: begin
                // Include a pixel counted this cycle so completion is not delayed
                if (pix_leidos_d == n_pix_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_DONE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            words_left_q <= '0;
            pix_leidos_q <= '0;
            n_pix_q      <= '0;
            mem_data_q   <= '0;
            save_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef LECTOR_TIMEOUT_EN
            wd_q         <= '0;
            error_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            words_left_q <= words_left_d;
            pix_leidos_q <= pix_leidos_d;
            n_pix_q      <= n_pix_d;
            mem_data_q   <= mem_data_d;
            save_q       <= save_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef LECTOR_TIMEOUT_EN
            wd_q         <= wd_d;
            error_q      <= error_d;
`endif
        end
    end

    assign mem_addr      = addr_q;
    assign mem_read      = mem_read_c;
    assign memory_data   = mem_data_q;
    assign save_mem_data = save_q;
    assign busy          = busy_q;
    assign done          = done_q;
`ifdef LECTOR_TIMEOUT_EN
    assign error         = error_q;
`endif

endmodule
